// File: rtl/spm_inverse_scan.sv
// Inverse scan of a fixed 6-input function: streams every x with f(x) == target.
// Optional SPM_COUNT_EN adds a per-scan match counter on the match_count port.
module spm_inverse_scan (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  input  logic       req_target,
  output logic       req_ready,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [5:0] out_x,
  output logic       done,
  output logic       busy
`ifdef SPM_COUNT_EN
  ,
  output logic [6:0] match_count
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_t;

  state_t     state;
  logic [5:0] idx;
  logic       target;
  logic       hit;
  logic       adv;
  logic       last;

  function automatic logic maj3(
    input logic p,
    input logic q,
    input logic r
  );
    return (p & q) | (p & r) | (q & r);
  endfunction

  function automatic logic f_eval(
    input logic [5:0] x
  );
    logic a;
    logic b;
    logic c;
    logic d;
    a = x[3] & x[4];
    b = ~x[0] & x[1] & ~x[2];
    c = maj3(x[4], ~x[5], b);
    d = x[3] | x[5];
    return maj3(~a, c, d);
  endfunction

  assign hit  = (f_eval(idx) == target);
  assign adv  = ~hit | out_ready;
  assign last = (idx == 6'd63);

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign out_valid = (state == SCAN) & hit;
  assign out_x     = (state == SCAN) ? idx : 6'd0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      idx    <= 6'd0;
      target <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            target <= req_target;
            idx    <= 6'd0;
            state  <= SCAN;
          end
        end
        SCAN: begin
          // last index resolves into DONE instead of wrapping
          if (adv) begin
            if (last) state <= DONE;
            else      idx   <= idx + 6'd1;
          end
        end
        DONE: begin
          idx   <= 6'd0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SPM_COUNT_EN
  logic [6:0] cnt;
  logic       beat;

  assign beat = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= 7'd0;
      match_count <= 7'd0;
    end else begin
      if (req_valid & req_ready) cnt <= 7'd0;
      else if (beat)             cnt <= cnt + 7'd1;
      // the final beat may land in the same cycle as entry to DONE
      if ((state == SCAN) & adv & last)
        match_count <= cnt + {6'd0, beat};
    end
  end
`endif

endmodule

// File: doc/spm_inverse_scan.md
SPM_INVERSE_SCAN -- requirements
Module: spm_inverse_scan

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, synchronous, active-high.
REQ-003 req_valid  input  1  scan request present.
REQ-004 req_target  input  1  output value whose preimages are requested; sampled on accept.
REQ-005 req_ready  output  1  high only in IDLE; request accepted when req_valid & req_ready.
REQ-006 out_valid  output  1  out_x holds a matching input vector.
REQ-007 out_ready  input  1  consumer accepts beat when out_valid & out_ready.
REQ-008 out_x  output  6  matching input vector; bit i corresponds to x_i.
REQ-009 done  output  1  one-cycle pulse at end of scan.
REQ-010 busy  output  1  high in SCAN and DONE.
REQ-011 match_count  output  7  matches found in the last completed scan; present only with SPM_COUNT_EN.

Function
REQ-012 Evaluated function f(x), x = x5..x0, SHALL be: a = x3&x4; b = ~x0&x1&~x2; c = maj(x4,~x5,b); d = x3|x5; f = maj(~a,c,d).
REQ-013 Block SHALL emit, in ascending order, every x in 0..63 with f(x) == latched target, each exactly once.
REQ-014 FSM states IDLE, SCAN, DONE; IDLE->SCAN on accept; SCAN->DONE after idx 63 resolved; DONE->IDLE after one cycle.
REQ-015 On accept in cycle t: target latched, idx = 0; SCAN begins at t+1.
REQ-016 In SCAN, out_valid = (f(idx) == target); out_x = idx; evaluation is combinational on idx, zero added latency.
REQ-017 idx SHALL advance when f(idx) != target, or when match and out_ready is high; otherwise hold.
REQ-018 While out_valid is high and out_ready is low, out_x and out_valid SHALL remain stable.
REQ-019 With out_ready held high, SCAN lasts exactly 64 cycles (t+1..t+64); done pulses at t+65; each stall cycle delays done by one.
REQ-020 When idx 63 is resolved, 6-bit idx SHALL NOT wrap into a second pass; FSM moves to DONE.
REQ-021 req_ready = 0 in SCAN and DONE; requests there are ignored, not queued.
REQ-022 Request in the DONE cycle SHALL NOT be accepted; earliest accept is the following IDLE cycle.
REQ-023 out_valid = 0 outside SCAN; done = 1 only in DONE.

Reset
REQ-024 rst high SHALL force IDLE, idx = 0, target = 0 on the next edge, regardless of state.
REQ-025 Reset values: req_ready = 1 after reset; out_valid = 0, out_x = 0, done = 0, busy = 0, match_count = 0.
REQ-026 Reset mid-scan SHALL abandon the scan with no done pulse; match_count = 0.

Configuration
REQ-027 Macro SPM_COUNT_EN defined: 7-bit match counter increments per accepted beat, clears on accept, and is copied to match_count on entry to DONE; match_count holds until the next DONE or reset.
REQ-028 SPM_COUNT_EN undefined: match_count port and counter logic absent; all other behaviour identical.

Verification
REQ-029 target 0, out_ready = 1 -> 14 beats x = 0,1,3,4,5,6,7,56,57,59,60,61,62,63; done at t+65; match_count = 14.
REQ-030 target 1, out_ready = 1 -> 50 beats, first x = 2, then 8..55 contiguous, last x = 58; done at t+65; match_count = 50.
REQ-031 target 1, out_ready low 5 cycles while x = 2 presented -> out_x stays 2, out_valid high throughout; done at t+70.
REQ-032 rst pulsed while idx = 30 -> next cycle IDLE, out_valid = 0, req_ready = 1, no done; new request rescans from x = 0.
REQ-033 req_valid held high through scan and DONE -> exactly one accept, then the next accept occurs on the first IDLE cycle after DONE.
REQ-034 Build without SPM_COUNT_EN -> beat sequences and done timing of REQ-029/030 unchanged; no match_count port.
